sauria_addr_decoder: RTL
========================

// Module: sauria_addr_decoder
// PURPOSE
//  Responder-side address decoder for the SAURIA internal address space.
//  - Accepts one req/gnt/rvalid bus from the host bridge.
//  - Decodes each request to CFG, SRAMA, SRAMB, SRAMC or unmapped; forwards to the target; returns responses in issue order.
//  - Sits between the host interface and the config register file / SRAM banks.
// PARAMETERS
//  ADDR_W   32  request address width
//  DATA_W   32  data width
//  MAX_OUT   4  max outstanding requests (order FIFO depth, power of 2, >=2)
// PORTS
//  i_clk         in   1              clock
//  i_rstn        in   1              async active-low reset
//  i_req         in   1              host request valid
//  i_addr        in   ADDR_W         host byte address
//  i_we          in   1              1=write 0=read
//  i_be          in   DATA_W/8       byte enables
//  i_wdata       in   DATA_W         write data
//  o_gnt         out  1              request accepted this cycle
//  o_rvalid      out  1              response valid (1 cycle pulse)
//  o_rdata       out  DATA_W         read data
//  o_err         out  1              error response
//  o_tgt_req     out  4              per-target req [0]=CFG [1]=A [2]=B [3]=C
//  i_tgt_gnt     in   4              per-target grant
//  o_tgt_addr    out  ADDR_W         offset address (shared)
//  o_tgt_we/be/wdata  out            shared copies of i_we/i_be/i_wdata
//  o_cfg_region  out  3              0=REGS 1=CON 2=ACT 3=WEI 4=OUT
//  i_tgt_rvalid  in   4              per-target response valid
//  i_tgt_rdata   in   4xDATA_W       per-target read data
// BEHAVIOUR
//  - Reset: all outputs 0, order FIFO empty, last_tgt=CFG.
//  - Decode (combinational):
//    - mem = addr[19:16] (mask 000F_0000): 0 CFG, 1 SRAMA, 2 SRAMB, 3 SRAMC, other UNMAPPED.
//    - addr[31:20]!=0 -> UNMAPPED.
//    - CFG: region = addr[15:9] (mask 0000_FE00); 0..4 -> o_cfg_region, >4 -> UNMAPPED.
//    - o_tgt_addr: SRAM = addr[15:0]; CFG = addr[8:0]; upper bits zero.
//  - Address phase is zero latency:
//    - o_tgt_req[t] = i_req & sel==t & ~stall.
//    - o_gnt = i_tgt_gnt[sel] & o_tgt_req[sel]; UNMAPPED: o_gnt = i_req & ~stall.
//  - stall = (count==MAX_OUT) | (count!=0 & sel!=last_tgt). Responses can only come from one target at a time, so ordering is guaranteed.
//  - Push: each grant pushes the target id (CFG/A/B/C/ERR) to the FIFO; last_tgt <= id.
//  - Response path (registered, +1 cycle):
//    - When i_tgt_rvalid[head] is high: o_rvalid=1, o_rdata=i_tgt_rdata[head], o_err=0; pop.
//    - When head==ERR: respond the cycle after it reaches head.
//  - Push and pop in the same cycle: count unchanged. At full, gnt is blocked even if a pop occurs that cycle.
//  - Ignored rvalid (assert in sim; never forwarded):
//    - i_tgt_rvalid from a non-head target, or with the FIFO empty.
//    - Late target responses after a reset mid-operation; outstanding requests are dropped by reset.
//  - Writes also await a response (targets ack writes with rvalid).
// CONFIGURATION
//  SAURIA_DEC_ERR_RESP_EN defined:
//    UNMAPPED -> o_err=1, o_rdata=32'hDEAD_BEEF.
//  Undefined:
//    UNMAPPED still granted and completed (bus never hangs) with o_err=0, o_rdata=0; writes dropped.
// STRUCTURE
//  - Shared package: typedef enum logic[2:0] {TGT_CFG,TGT_SRAMA,TGT_SRAMB,TGT_SRAMC,TGT_ERR} sauria_tgt_e.
//  - Shared package: cfg_region_e; MEM/REG field LSB/width constants derived from the SAURIA address masks and offsets.
//  - Sub-module sauria_rsp_order_fifo: MAX_OUT x 3b sync FIFO with push/pop/full/empty/count.
// TESTING
//  1 Read 0x0002_0040, B gnt=1, rvalid+1 rdata=0x1234 -> o_tgt_req=4'b0100, addr 0x40, o_rdata 0x1234 one cycle later.
//  2 Write 0x0000_0604 -> o_tgt_req[0], o_cfg_region=3, o_tgt_addr=0x004; response after CFG rvalid.
//  3 Read 0x0005_0000 and 0x0000_0C00 -> both UNMAPPED; with macro: o_err=1, rdata DEADBEEF; without: err=0, rdata 0.
//  4 Issue 5 reads to A with rvalid held low -> 4 granted, 5th stalls (o_gnt=0) until first rvalid pops.
//  5 Read A outstanding, then request C -> C stalled until A response returns; responses in order A then C.
//  6 Assert i_rstn low with 3 outstanding, then A rvalid after reset -> no o_rvalid, count 0.

Source files
------------

// File: rtl/sauria_addr_decoder_pkg.sv
// SAURIA address decoder shared types.
// Target ids, config regions and address-field positions.
package sauria_addr_decoder_pkg;

  typedef enum logic [2:0] {
    TGT_CFG,
    TGT_SRAMA,
    TGT_SRAMB,
    TGT_SRAMC,
    TGT_ERR
  } sauria_tgt_e;

  typedef enum logic [2:0] {
    CFG_REGS,
    CFG_CON,
    CFG_ACT,
    CFG_WEI,
    CFG_OUT
  } cfg_region_e;

  // mem field is mask 000F_0000, region field is mask 0000_FE00
  localparam int MEM_LSB    = 16;
  localparam int MEM_W      = 4;
  localparam int HI_LSB     = 20;
  localparam int REG_LSB    = 9;
  localparam int REG_W      = 7;
  localparam int CFG_OFF_W  = 9;
  localparam int SRAM_OFF_W = 16;

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  function automatic sauria_tgt_e mem_tgt(
    input logic [MEM_W-1:0] mem
  );
    sauria_tgt_e t;
    case (mem)
      4'd0:    t = TGT_CFG;
      4'd1:    t = TGT_SRAMA;
      4'd2:    t = TGT_SRAMB;
      4'd3:    t = TGT_SRAMC;
      default: t = TGT_ERR;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/sauria_addr_decoder_rsp_order_fifo.sv
// Response-order FIFO for the SAURIA address decoder.
// Holds the target id of each granted request, oldest at head.
module sauria_rsp_order_fifo
  import sauria_addr_decoder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  sauria_tgt_e            data_i,
  output sauria_tgt_e            data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  sauria_tgt_e   mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TGT_CFG;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sauria_addr_decoder.sv
// SAURIA responder-side address decoder with in-order responses.
// SAURIA_DEC_ERR_RESP_EN: unmapped accesses return err + DEADBEEF.
module sauria_addr_decoder
  import sauria_addr_decoder_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_req,
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_we,
  input  logic [DATA_W/8-1:0]    i_be,
  input  logic [DATA_W-1:0]      i_wdata,
  output logic                   o_gnt,
  output logic                   o_rvalid,
  output logic [DATA_W-1:0]      o_rdata,
  output logic                   o_err,
  output logic [3:0]             o_tgt_req,
  input  logic [3:0]             i_tgt_gnt,
  output logic [ADDR_W-1:0]      o_tgt_addr,
  output logic                   o_tgt_we,
  output logic [DATA_W/8-1:0]    o_tgt_be,
  output logic [DATA_W-1:0]      o_tgt_wdata,
  output logic [2:0]             o_cfg_region,
  input  logic [3:0]             i_tgt_rvalid,
  input  logic [3:0][DATA_W-1:0] i_tgt_rdata
);

  localparam int CW = $clog2(MAX_OUT) + 1;

  sauria_tgt_e       sel, head, last_tgt_q;
  logic [MEM_W-1:0]  mem_f;
  logic [REG_W-1:0]  reg_f;
  logic [CW-1:0]     count;
  logic              full, empty, stall, go, push, pop;
  logic              rvalid_q, rvalid_d, err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  assign o_tgt_we    = i_we;
  assign o_tgt_be    = i_be;
  assign o_tgt_wdata = i_wdata;

  always_comb begin
    mem_f = i_addr[MEM_LSB +: MEM_W];
    reg_f = i_addr[REG_LSB +: REG_W];
    sel   = mem_tgt(mem_f);
    if (|i_addr[ADDR_W-1:HI_LSB]) begin
      sel = TGT_ERR;
    end else if (sel == TGT_CFG && reg_f > REG_W'(CFG_OUT)) begin
      sel = TGT_ERR;
    end
  end

  always_comb begin
    o_tgt_addr   = '0;
    o_cfg_region = '0;
    unique case (1'b1)
      (sel == TGT_CFG): begin
        o_tgt_addr   = ADDR_W'(i_addr[CFG_OFF_W-1:0]);
        o_cfg_region = reg_f[2:0];
      end
      (sel inside {TGT_SRAMA, TGT_SRAMB, TGT_SRAMC}):
        o_tgt_addr = ADDR_W'(i_addr[SRAM_OFF_W-1:0]);
      default: o_tgt_addr = '0;
    endcase
  end

  // one target in flight at a time keeps responses in issue order
  assign stall = full | ((|count) & (sel != last_tgt_q));
  assign go    = i_req & ~stall;

  always_comb begin
    o_tgt_req = '0;
    if (go && sel != TGT_ERR) o_tgt_req[sel[1:0]] = 1'b1;
    if (sel == TGT_ERR) o_gnt = go;
    else o_gnt = o_tgt_req[sel[1:0]] & i_tgt_gnt[sel[1:0]];
  end

  assign push = o_gnt;

  always_comb begin
    pop      = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (!empty) begin
      if (head == TGT_ERR) begin
        pop = 1'b1;
`ifdef SAURIA_DEC_ERR_RESP_EN
        rdata_d = DATA_W'(ERR_RDATA);
        err_d   = 1'b1;
`endif
      end else if (i_tgt_rvalid[head[1:0]]) begin
        pop     = 1'b1;
        rdata_d = i_tgt_rdata[head[1:0]];
      end
      rvalid_d = pop;
    end
  end

  sauria_rsp_order_fifo #(
    .DEPTH (MAX_OUT)
  ) u_order (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      last_tgt_q <= TGT_CFG;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      if (push) last_tgt_q <= sel;
    end
  end

  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_err    = err_q;

endmodule
